adder_pipe: RTL and testbench

ADDER_PIPE -- requirements
Module: adder_pipe

---
 rtl/adder_pkg.sv | 11 +
 rtl/adder_seg.sv | 16 +
 rtl/adder_pipe.sv | 155 +++++++++++++++
 tb/tb_adder_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// One segment of the carry-pipelined adder: SEG_W-bit add with carry in/out.
module adder_seg
  import adder_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             ci_i,
  output logic [SEG_W-1:0] s_o,
  output logic             co_o
);

  assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG_W{1'b0}}, ci_i};

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined add/sub, one WIDTH/STAGES-bit segment per stage, valid/ready flow.
// Define ADDER_PIPE_SAT_EN to add the sat input and signed-overflow clamping.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef ADDER_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Sum,
  output logic             ovf
);

  localparam int SEG_W = seg_width(WIDTH, STAGES);
  localparam int L     = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be >= 2 and a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic            advance;
  logic [STAGES:1] vld_pipe;
  logic [WIDTH:0]  sum_q, sum_d;
  logic            ovf_q, ovf_d;

  assign advance   = enable & (~vld_pipe[STAGES] | out_ready);
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];
  assign Sum       = sum_q;
  assign ovf       = ovf_q;

  // Empty slots shift like beats so bubbles are never collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Each stage consumes the low segment of the pending operands; consumed
  // bits are dropped and finished result segments accumulate above.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int PEND = WIDTH - s*SEG_W;
    localparam int DONE = s*SEG_W;

    logic [PEND-1:0]       a_in, b_in;
    logic [DONE+SEG_W-1:0] r_new;
    logic [SEG_W-1:0]      b_seg, seg_s;
    logic                  m_in, c_in, v_in, seg_co;
`ifdef ADDER_PIPE_SAT_EN
    logic                  sat_in;
`endif

    if (s == 0) begin : g_src
      assign a_in  = A;
      assign b_in  = B;
      assign m_in  = mode;
      assign c_in  = (mode == MODE_SUB);
      assign v_in  = in_valid;
      assign r_new = seg_s;
`ifdef ADDER_PIPE_SAT_EN
      assign sat_in = sat;
`endif
    end else begin : g_src
      assign a_in  = g_stage[s-1].g_reg.a_q;
      assign b_in  = g_stage[s-1].g_reg.b_q;
      assign m_in  = g_stage[s-1].g_reg.m_q;
      assign c_in  = g_stage[s-1].g_reg.c_q;
      assign v_in  = vld_pipe[s];
      assign r_new = {seg_s, g_stage[s-1].g_reg.r_q};
`ifdef ADDER_PIPE_SAT_EN
      assign sat_in = g_stage[s-1].g_reg.sat_q;
`endif
    end

    assign b_seg = b_in[SEG_W-1:0] ^ {SEG_W{m_in == MODE_SUB}};

    adder_seg #(.SEG_W(SEG_W)) u_seg (
      .a_i  (a_in[SEG_W-1:0]),
      .b_i  (b_seg),
      .ci_i (c_in),
      .s_o  (seg_s),
      .co_o (seg_co)
    );

    if (s < L) begin : g_reg
      logic [PEND-SEG_W-1:0] a_q, b_q;
      logic [DONE+SEG_W-1:0] r_q;
      logic                  m_q, c_q;
`ifdef ADDER_PIPE_SAT_EN
      logic                  sat_q;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
          m_q <= 1'b0;
          c_q <= 1'b0;
`ifdef ADDER_PIPE_SAT_EN
          sat_q <= 1'b0;
`endif
        end else if (advance && v_in) begin
          a_q <= a_in[PEND-1:SEG_W];
          b_q <= b_in[PEND-1:SEG_W];
          r_q <= r_new;
          m_q <= m_in;
          c_q <= seg_co;
`ifdef ADDER_PIPE_SAT_EN
          sat_q <= sat_in;
`endif
        end
      end
    end else begin : g_out
      // Top segment holds the sign bits: a_in MSB and the (possibly inverted) b MSB.
      always_comb begin
        ovf_d = (a_in[SEG_W-1] == b_seg[SEG_W-1]) && (r_new[WIDTH-1] != a_in[SEG_W-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (sat_in && ovf_d)
          sum_d = a_in[SEG_W-1] ? {2'b01, {(WIDTH-1){1'b0}}} : {2'b00, {(WIDTH-1){1'b1}}};
        else
          sum_d = {seg_co, r_new};
`else
        sum_d = {seg_co, r_new};
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          sum_q <= '0;
          ovf_q <= 1'b0;
        end else if (advance && v_in) begin
          sum_q <= sum_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe: directed vectors, flow-control sequences, random traffic.
module tb_adder_pipe;
  import adder_pkg::*;

  localparam int W = 16;
  localparam int S = 2;
`ifdef ADDER_PIPE_SAT_EN
  localparam bit SAT_BUILD = 1'b1;
`else
  localparam bit SAT_BUILD = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, enable, in_valid, in_ready, mode;
  logic [W-1:0] A, B;
  logic         out_valid, out_ready, ovf;
  logic [W:0]   Sum;
`ifdef ADDER_PIPE_SAT_EN
  logic         sat;
`endif

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .A         (A),
    .B         (B),
`ifdef ADDER_PIPE_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .ovf       (ovf)
  );

  typedef struct packed { logic [W:0] sum; logic ovf; } res_t;
  typedef struct { logic md; logic [W-1:0] a; logic [W-1:0] b; bit st; logic [W:0] sum; logic ovf; } vec_t;

  int   n_total = 0;
  int   n_pass  = 0;
  res_t exp_q[$];
  bit   mv[S];            // model slot occupancy, mv[S-1] is the output slot
  bit   prev_hold = 0;
  logic [W:0] prev_sum;
  logic prev_ovf, prev_ov;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Plain integer arithmetic: unsigned result with carry/no-borrow, signed range test.
  function automatic res_t ref_model(input logic md, input logic [W-1:0] a, input logic [W-1:0] b, input bit st);
    longint ua, ub, sa, sb, sr, mx, mn, raw;
    res_t r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    mx = (longint'(1) << (W-1)) - 1;
    mn = -(longint'(1) << (W-1));
    if (md == MODE_SUB) begin
      raw = ua - ub + (longint'(1) << W);
      sr  = sa - sb;
    end else begin
      raw = ua + ub;
      sr  = sa + sb;
    end
    r.ovf = (sr > mx) || (sr < mn);
    if (st && r.ovf) raw = (sr > mx) ? mx : -mn;
    r.sum = raw[W:0];
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive, check against the model, update the model, advance to next negedge.
  task automatic step(input bit r, input bit en, input bit iv, input logic md, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit ordy, input bit st, output bit acc);
    bit adv, cons;
    res_t e;
    rst = r; enable = en; in_valid = iv; mode = md; A = a; B = b; out_ready = ordy;
`ifdef ADDER_PIPE_SAT_EN
    sat = st;
`endif
    #1;
    if (prev_hold) chk("hold_stable", {13'b0, out_valid, ovf, Sum}, {13'b0, prev_ov, prev_ovf, prev_sum});
    adv  = en && (!mv[S-1] || ordy);
    cons = !r && adv && mv[S-1];
    acc  = !r && adv && iv;
    if (!r) begin
      chk("out_valid", out_valid, mv[S-1]);
      chk("in_ready", in_ready, adv);
    end
    if (cons) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard: result consumed with no beat expected");
      end else begin
        e = exp_q.pop_front();
        chk("sum", Sum, e.sum);
        chk("ovf", ovf, e.ovf);
      end
    end
    if (acc) exp_q.push_back(ref_model(md, a, b, st && SAT_BUILD));
    prev_hold = !r && !adv;
    prev_sum = Sum; prev_ovf = ovf; prev_ov = out_valid;
    if (r) begin
      foreach (mv[i]) mv[i] = 0;
      exp_q.delete();
    end else if (adv) begin
      for (int i = S-1; i > 0; i--) mv[i] = mv[i-1];
      mv[0] = iv;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bit acc;
    step(0, 1, 0, 1'b0, '0, '0, 1, 0, acc);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < S + 3; k++) idle();
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Present nb beats back to back (each held until accepted) with enable/out_ready windows low.
  task automatic stream(input int nb, input int en_lo, input int en_hi, input int rdy_lo, input int rdy_hi, input string tag);
    int sent = 0;
    bit acc, en, ordy;
    logic md;
    logic [W-1:0] a, b;
    md = 1'($urandom); a = pick(); b = pick();
    for (int cyc = 0; cyc < 60 && sent < nb; cyc++) begin
      en   = !(cyc >= en_lo && cyc <= en_hi);
      ordy = !(cyc >= rdy_lo && cyc <= rdy_hi);
      step(0, en, 1, md, a, b, ordy, 0, acc);
      if (acc) begin
        sent++;
        md = 1'($urandom); a = pick(); b = pick();
      end
    end
    drain(tag);
    chk({tag, "_accepted"}, sent, nb);
  endtask

  vec_t tbl[$];

  initial begin
    bit acc;
    tbl.push_back('{MODE_ADD, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0});
    tbl.push_back('{MODE_SUB, 16'h0003, 16'h0005, 1'b0, 17'h0FFFE, 1'b0});
    tbl.push_back('{MODE_SUB, 16'h0005, 16'h0003, 1'b0, 17'h10002, 1'b0});
    tbl.push_back('{MODE_ADD, 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1});
    tbl.push_back('{MODE_ADD, 16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1});
    tbl.push_back('{MODE_SUB, 16'h8000, 16'h0001, 1'b0, 17'h17FFF, 1'b1});
    tbl.push_back('{MODE_SUB, 16'h0000, 16'h0000, 1'b0, 17'h10000, 1'b0});
    tbl.push_back('{MODE_SUB, 16'h0000, 16'h8000, 1'b0, 17'h08000, 1'b1});
    tbl.push_back('{MODE_ADD, 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0});
    if (SAT_BUILD) begin
      tbl.push_back('{MODE_ADD, 16'h7FFF, 16'h0001, 1'b1, 17'h07FFF, 1'b1});
      tbl.push_back('{MODE_SUB, 16'h8000, 16'h0001, 1'b1, 17'h08000, 1'b1});
      tbl.push_back('{MODE_ADD, 16'h1234, 16'h4321, 1'b1, 17'h05555, 1'b0});
    end

    rst = 1; enable = 0; in_valid = 0; mode = 0; A = '0; B = '0; out_ready = 0;
`ifdef ADDER_PIPE_SAT_EN
    sat = 0;
`endif
    @(negedge clk);
    step(1, 0, 0, 1'b0, '0, '0, 0, 0, acc);
    step(1, 1, 1, 1'b0, 16'hAAAA, 16'h5555, 1, 0, acc);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_ovf", ovf, 0);

    // Directed vectors: result must appear exactly S cycles after acceptance.
    foreach (tbl[i]) begin
      step(0, 1, 1, tbl[i].md, tbl[i].a, tbl[i].b, 1, tbl[i].st, acc);
      chk($sformatf("tbl%0d_accept", i), acc, 1);
      for (int k = 1; k < S; k++) idle();
      chk($sformatf("tbl%0d_valid", i), out_valid, 1);
      chk($sformatf("tbl%0d_sum", i), Sum, tbl[i].sum);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      idle();
    end

    // Reset with two beats in flight, then a fresh beat.
    step(0, 1, 1, MODE_ADD, 16'h1111, 16'h2222, 0, 0, acc);
    step(0, 1, 1, MODE_SUB, 16'h3333, 16'h1111, 0, 0, acc);
    step(1, 1, 1, MODE_ADD, 16'hFFFF, 16'hFFFF, 1, 0, acc);
    chk("rstfl_out_valid", out_valid, 0);
    chk("rstfl_sum", Sum, 0);
    chk("rstfl_ovf", ovf, 0);
    step(0, 1, 1, MODE_ADD, 16'h1234, 16'h00FF, 1, 0, acc);
    chk("rstfl_accept", acc, 1);
    for (int k = 1; k < S; k++) idle();
    chk("rstfl_new_valid", out_valid, 1);
    chk("rstfl_new_sum", Sum, 17'h01333);
    idle();

    stream(6, -1, -1, 3, 5, "stall");
    stream(8, 3, 6, -1, -1, "enable");
    stream(10, 2, 3, 5, 8, "mixed");

    for (int c = 0; c < 600; c++) begin
      step(($urandom % 150) == 0, ($urandom % 8) != 0, ($urandom % 3) != 0, 1'($urandom),
           pick(), pick(), ($urandom % 4) != 0, SAT_BUILD && ($urandom % 2 == 1), acc);
    end
    drain("rand");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
